// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit holding the MIPS32 HI/LO registers.
// Handles mult, multu, div, divu (34-cycle start/busy/done handshake) and
// mthi, mtlo (single-edge writes). Optional build macro MDU_FAST_MULT_EN
// replaces the iterative multiply with a single-cycle product; divide is
// always iterative.
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;      // negate product / quotient in FIX
    logic        neg_r;      // negate remainder in FIX (dividend sign)
    logic        div_zero;
    logic [31:0] opa;        // |A| or raw A
    logic [31:0] opb;        // |B| or raw B
    logic [63:0] acc;        // product, or {remainder, quotient}

    logic        op_mul, op_div, op_signed, accept;
    logic [63:0] mul_nx, div_nx, prod_fix;
    logic [32:0] rem_sh, diff;
    logic [31:0] hi_res, lo_res;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

    assign op_mul    = (Op == OP_MULT) || (Op == OP_MULTU);
    assign op_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
    assign op_signed = ~Op[0];
    assign accept    = (state == IDLE) && start;
    assign busy      = (state != IDLE);

`ifdef MDU_FAST_MULT_EN
    logic signed [63:0] fast_s;
    logic        [63:0] fast_u;
    assign fast_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign fast_u = {32'd0, A} * {32'd0, B};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && (op_mul || op_div)) begin
`ifdef MDU_FAST_MULT_EN
                    state_nx = op_mul ? FIX : PREP;
`else
                    state_nx = PREP;
`endif
                end
            end
            PREP:    state_nx = RUN;
            RUN:     state_nx = (cnt == 5'd0) ? FIX : RUN;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One iteration step (MSB first) plus the sign-corrected final result
    always_comb begin
        mul_nx   = {acc[62:0], 1'b0} + (opb[cnt] ? {32'd0, opa} : 64'd0);
        rem_sh   = {acc[63:32], opa[cnt]};
        diff     = rem_sh - {1'b0, opb};
        div_nx   = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                            : {diff[31:0],   acc[30:0], 1'b1};
        prod_fix = neg64(acc, neg_q);
        if (is_div) begin
            // With B=0 the remainder path shifts the whole dividend through,
            // so HI comes out as A after sign restore; only LO is forced.
            hi_res = neg32(acc[63:32], neg_r);
            lo_res = div_zero ? 32'hFFFF_FFFF : neg32(acc[31:0], neg_q);
        end else begin
            hi_res = prod_fix[63:32];
            lo_res = prod_fix[31:0];
        end
    end

    // Operand latch and accumulator datapath (no reset needed)
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept && (op_mul || op_div)) begin
                    is_div   <= op_div;
                    opa      <= abs32(A, op_signed);
                    opb      <= abs32(B, op_signed);
                    neg_q    <= op_signed & (A[31] ^ B[31]);
                    neg_r    <= op_signed & A[31];
                    div_zero <= (B == 32'd0);
`ifdef MDU_FAST_MULT_EN
                    if (op_mul) begin
                        acc   <= op_signed ? fast_s : fast_u;
                        neg_q <= 1'b0;
                    end
`endif
                end
            end
            PREP:    acc <= 64'd0;
            RUN:     acc <= is_div ? div_nx : mul_nx;
            default: ;
        endcase
    end

    // Control: iteration counter, done pulse, architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 5'd0;
            done <= 1'b0;
            HI   <= 32'd0;
            LO   <= 32'd0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept && (Op == OP_MTHI)) HI <= A;
                    if (accept && (Op == OP_MTLO)) LO <= A;
                end
                PREP: cnt <= 5'd31;
                RUN:  if (cnt != 5'd0) cnt <= cnt - 5'd1;
                FIX: begin
                    HI <= hi_res;
                    LO <= lo_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed bench for mdu with a cycle-level reference model and
// hand-computed literal expectations.
module tb_mdu;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  Op = 6'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, done;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    mdu dut (
        .clk(clk), .reset(reset), .start(start), .Op(Op), .A(A), .B(B),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining cycles of the in-flight op and its result
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    logic        m_done = 1'b0;

    task automatic compute(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint sa, sb, q, rm;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  r = 64'(sa * sb);
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {32'(rm), 32'(q)};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {32'({32'd0, a} % {32'd0, b}), 32'({32'd0, a} / {32'd0, b})};
            end
        endcase
        p_hi = r[63:32];
        p_lo = r[31:0];
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (start) begin
                if (Op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
                    compute(Op, A, B);
                    m_left = 34;
                end else if (Op == OP_MTHI) m_hi = A;
                else if (Op == OP_MTLO) m_lo = A;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_left > 0});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("HI", HI, m_hi);
            check("LO", LO, m_lo);
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; Op = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; Op = 6'd0; A = 32'd0; B = 32'd0;
    endtask

    // Returns at the negedge of the done cycle; counts busy cycles seen
    task automatic wait_done(input string name, output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int bc;
        issue(op, a, b);
        wait_done(name, bc);
        check({name, "_hi"}, HI, ehi);
        check({name, "_lo"}, LO, elo);
    endtask

    initial begin
        int bc;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // multu max*max with busy-length check
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", bc);
        check("multu_busy_len", bc, 32'd34);
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_z", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_op("div_z", OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Ignored opcode: no busy afterwards
        issue(6'b100000, 32'd1, 32'd2);
        check("bad_op_busy", {31'd0, busy}, 32'd0);

        // mtlo during a busy div is ignored; mthi in the done cycle is taken
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1; Op = OP_MTLO; A = 32'd5;
        @(negedge clk);
        start = 1'b0; Op = 6'd0; A = 32'd0;
        check("mtlo_ignored", LO, 32'h8000_0000);
        wait_done("div_100_7", bc);
        check("div_100_7_lo", LO, 32'd14);
        check("div_100_7_hi", HI, 32'd2);
        start = 1'b1; Op = OP_MTHI; A = 32'd9;
        @(negedge clk);
        start = 1'b0; Op = 6'd0; A = 32'd0;
        check("mthi_hi", HI, 32'd9);
        check("mthi_no_done", {31'd0, done}, 32'd0);
        check("mthi_no_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a mult
        issue(OP_MULT, 32'd123, 32'd456);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        repeat (30) @(negedge clk);
        check("rst_mid_no_done", {31'd0, done}, 32'd0);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
